// File: rtl/boot_loader_if.sv
// Byte-stream receive and instruction-memory write signals of the boot loader.
// master: the controller; slave: the byte source / memory side.
interface boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot loader: 16-bit LE word count, then LE 32-bit words written to imem, then CPU release.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module boot_loader_ctrl #(
    parameter int unsigned MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    boot_loader_if.master   bus,
    output logic            cpu_reset,
    output logic            done,
    output logic            error
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {StHdr, StLoad, StWrite, StCheck, StRun, StErr} state_e;
`else
    typedef enum logic [2:0] {StHdr, StLoad, StWrite, StRun, StErr} state_e;
`endif

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [15:0] hdr_n;
    logic        xfer;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign xfer = bus.rx_valid && bus.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StHdr;
            byte_cnt_q <= 2'd0;
            count_q    <= 16'd0;
            idx_q      <= 16'd0;
            word_q     <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        idx_d      = idx_q;
        word_d     = word_q;
        hdr_n      = {bus.rx_data, count_q[7:0]};
`ifdef BOOT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StHdr: begin
                if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    if (byte_cnt_q == 2'd0) begin
                        count_d[7:0] = bus.rx_data;
                        byte_cnt_d   = 2'd1;
                    end else begin
                        count_d[15:8] = bus.rx_data;
                        byte_cnt_d    = 2'd0;
                        if (hdr_n == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = StCheck;
`else
                            state_d = StRun;
`endif
                        end else if ({16'd0, hdr_n} > MAX_WORDS) begin
                            state_d = StErr;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
            end
            StLoad: begin
                if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d = idx_q + 16'd1;
                // 17-bit compare so idx+1 can never wrap
                if (({1'b0, idx_q} + 17'd1) < {1'b0, count_q}) begin
                    state_d = StLoad;
                end else begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StRun;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    state_d = (bus.rx_data == csum_q) ? StRun : StErr;
                end
            end
`endif
            StRun, StErr: begin
                state_d = state_q;
            end
            default: begin
                state_d = StHdr;
            end
        endcase
    end

`ifdef BOOT_CHECKSUM_EN
    assign bus.rx_ready = (state_q == StHdr) || (state_q == StLoad) || (state_q == StCheck);
`else
    assign bus.rx_ready = (state_q == StHdr) || (state_q == StLoad);
`endif
    assign bus.imem_we    = (state_q == StWrite);
    assign bus.imem_addr  = BASE_ADDR + {14'd0, idx_q, 2'b00};
    assign bus.imem_wdata = word_q;
    assign cpu_reset      = (state_q != StRun);
    assign done           = (state_q == StRun);
    assign error          = (state_q == StErr);

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Randomized bench for boot_loader_ctrl; a stream-level model predicts writes and final status.
// Build with BOOT_CHECKSUM_EN defined to exercise the checksum variant.
module tb_boot_loader_ctrl;
    localparam int unsigned MaxWords = 64;
    localparam logic [31:0] BaseAddr = 32'hFFFF_FF80; // long loads wrap past 2^32

    logic clk = 1'b0;
    logic reset;
    logic cpu_reset, done, error;

    boot_loader_if bus ();

    boot_loader_ctrl #(
        .MAX_WORDS(MaxWords),
        .BASE_ADDR(BaseAddr)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    int done_cyc = -1;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] preset_words[$];

`ifdef BOOT_CHECKSUM_EN
    localparam bit HasCsum = 1'b1;
`else
    localparam bit HasCsum = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reset with a byte on offer: that byte must be discarded.
    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        check_eq({name, "_rst_rx_ready"}, bus.rx_ready, 1);
        check_eq({name, "_rst_imem_we"}, bus.imem_we, 0);
        check_eq({name, "_rst_cpu_reset"}, cpu_reset, 1);
        check_eq({name, "_rst_done"}, done, 0);
        check_eq({name, "_rst_error"}, error, 0);
        check_eq({name, "_rst_addr"}, bus.imem_addr, BaseAddr);
        check_eq({name, "_rst_wdata"}, bus.imem_wdata, 0);
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cyc = -1;
    endtask

    // Called just after a negedge; returns just after a later negedge.
    task automatic send_byte(input logic [7:0] b, input string name);
        int waited = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        while (!bus.rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.rx_ready) begin
            check_eq({name, "_rx_ready_timeout"}, bus.rx_ready, 1);
        end else begin
            @(posedge clk);
            last_xfer_cyc = cyc + 1;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_load(input int n, input bit bad_csum, input int stall_at, input string name);
        logic [7:0]  s[$];
        logic [31:0] exp_words[$];
        logic [31:0] w;
        logic [7:0]  x;
        bit          exp_err;
        int          nw;
        int          exp_done_cyc;

        do_reset(name);
        exp_err = (n > int'(MaxWords));
        nw = exp_err ? 0 : n;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        for (int i = 0; i < nw; i++) begin
            w = (i < preset_words.size()) ? preset_words[i] : $urandom;
            exp_words.push_back(w);
            for (int k = 0; k < 4; k++) s.push_back(w[8*k +: 8]);
        end
        preset_words.delete();
        if (HasCsum && !exp_err) begin
            x = 8'h00;
            foreach (s[i]) x ^= s[i];
            if (bad_csum) x ^= 8'h5A;
            s.push_back(x);
            exp_err = bad_csum;
        end

        foreach (s[i]) begin
            send_byte(s[i], name);
            if (i == stall_at) begin
                repeat (10) @(negedge clk);
                check_eq($sformatf("%s_stall_writes", name), wr_addr_q.size(), (i - 1) / 4);
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        // Terminal states must ignore further bytes.
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h00;
        repeat (5) @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);

        check_eq({name, "_nwrites"}, wr_addr_q.size(), nw);
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", name, i), wr_addr_q[i], BaseAddr + 32'(4 * i));
            check_eq($sformatf("%s_data%0d", name, i), wr_data_q[i], exp_words[i]);
        end
        check_eq({name, "_done"}, done, !exp_err);
        check_eq({name, "_error"}, error, exp_err);
        check_eq({name, "_cpu_reset"}, cpu_reset, exp_err);
        check_eq({name, "_rx_ready"}, bus.rx_ready, 0);
        if (!exp_err) begin
            exp_done_cyc = last_xfer_cyc + ((n > 0 && !HasCsum) ? 1 : 0);
            check_eq({name, "_done_cycle"}, done_cyc, exp_done_cyc);
        end else begin
            check_eq({name, "_never_done"}, done_cyc < 0, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;

        run_load(0, 1'b0, -1, "empty");
        preset_words.push_back(32'h0000_0013);
        preset_words.push_back(32'h0010_0093);
        run_load(2, 1'b0, -1, "two_words");
        run_load(65, 1'b0, -1, "too_big");
        run_load(64, 1'b0, -1, "max_wrap");
        run_load(1, 1'b0, 3, "stall");

        // Abort mid-word, then a fresh stream must load cleanly.
        do_reset("midword");
        send_byte(8'h02, "midword");
        send_byte(8'h00, "midword");
        send_byte(8'h11, "midword");
        send_byte(8'h22, "midword");
        send_byte(8'h33, "midword");
        repeat (3) @(negedge clk);
        check_eq("midword_no_write", wr_addr_q.size(), 0);
        preset_words.push_back(32'hDEAD_BEEF);
        run_load(1, 1'b0, -1, "after_abort");

        if (HasCsum) begin
            preset_words.push_back(32'h1234_5678);
            run_load(1, 1'b0, -1, "csum_good");
            preset_words.push_back(32'h1234_5678);
            run_load(1, 1'b1, -1, "csum_bad");
        end

        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 5))
                0:       n = $urandom_range(65, 300);
                1:       n = $urandom_range(60, 64);
                default: n = $urandom_range(0, 6);
            endcase
            run_load(n, 1'(($urandom_range(0, 1))), $urandom_range(2, 9),
                     $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 SHALL have parameter: MAX_WORDS, 64, largest program size in 32-bit words accepted.
REQ-002 SHALL have parameter: BASE_ADDR, 32'h0000_0000, instruction-memory byte address of word 0.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: rx_valid  input  1  byte-stream data valid.
REQ-006 SHALL have port: rx_data  input  8  byte-stream payload.
REQ-007 SHALL have port: rx_ready  output  1  controller accepts byte; transfer = rx_valid && rx_ready at clk edge.
REQ-008 SHALL have port: imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port: imem_addr  output  32  instruction-memory byte address.
REQ-010 SHALL have port: imem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port: cpu_reset  output  1  drives CPU core reset; high holds core and PC at reset.
REQ-012 SHALL have port: done  output  1  load complete, CPU running.
REQ-013 SHALL have port: error  output  1  load aborted; CPU held in reset.

Function
REQ-014 SHALL implement states HDR, LOAD, WRITE, (CHECK when configured), RUN, ERR.
REQ-015 HDR: SHALL accept 2 bytes, little-endian, forming 16-bit word count N.
REQ-016 HDR: N == 0 -> RUN on the cycle after the second byte; N > MAX_WORDS -> ERR; otherwise -> LOAD.
REQ-017 LOAD: SHALL assemble 4 bytes little-endian (first byte -> bits 7:0); after fourth byte -> WRITE.
REQ-018 WRITE: SHALL last exactly 1 cycle with imem_we=1, imem_addr=BASE_ADDR+4*idx, imem_wdata=assembled word; idx starts at 0 and increments by 1 after each write.
REQ-019 WRITE exit: idx+1 < N -> LOAD; else -> CHECK if configured, else RUN.
REQ-020 rx_ready SHALL be 1 only in HDR, LOAD, CHECK; 0 in WRITE, RUN, ERR.
REQ-021 Bytes presented while rx_ready=0 SHALL NOT be consumed or alter state.
REQ-022 rx_valid low mid-word SHALL stall assembly indefinitely with no loss of bytes already received.
REQ-023 cpu_reset SHALL be 1 in every state except RUN; it falls on the first cycle RUN is registered.
REQ-024 done SHALL be 1 only in RUN; error SHALL be 1 only in ERR.
REQ-025 RUN and ERR SHALL be terminal until reset.
REQ-026 imem_we SHALL be 0 outside WRITE; imem_addr/imem_wdata are don't-care when imem_we=0.
REQ-027 All outputs SHALL be registered or decoded from registered state only; no combinational rx_valid -> output path except none (rx_ready depends on state only).
REQ-028 Address arithmetic SHALL be 32-bit, wrap modulo 2^32.

Reset
REQ-029 reset=1 at a clk edge SHALL force state HDR, byte counter 0, idx 0, assembled word 0, checksum 0, regardless of current state, including mid-word and RUN.
REQ-030 Values during/after reset: rx_ready=1, imem_we=0, cpu_reset=1, done=0, error=0, imem_addr=BASE_ADDR, imem_wdata=0.
REQ-031 reset SHALL take priority over a simultaneous byte transfer; that byte is discarded.

Configuration
REQ-032 Macro BOOT_CHECKSUM_EN defined: SHALL accumulate XOR of all header and payload bytes; after final WRITE enter CHECK, accept one byte; equal to accumulator -> RUN, else -> ERR; N == 0 also goes through CHECK.
REQ-033 Macro BOOT_CHECKSUM_EN undefined: no CHECK state, no accumulator logic; final WRITE (or N == 0 header) -> RUN directly.

Verification
REQ-034 Bytes 02 00, 13 00 00 00, 93 00 10 00 (no checksum) -> writes 0x00000013 @0x0, 0x00100093 @0x4; cpu_reset falls and done=1 one cycle after second write.
REQ-035 Header 41 00 (N=65 > MAX_WORDS 64) -> error=1, cpu_reset stays 1, rx_ready=0, no imem_we ever.
REQ-036 N=1, rx_valid dropped for 10 cycles after byte 2 of word -> no write until byte 4 arrives; written word correct.
REQ-037 reset pulse after 3 payload bytes of word 1 -> state HDR, no write issued; fresh stream 01 00 EF BE AD DE writes 0xDEADBEEF @BASE_ADDR.
REQ-038 BOOT_CHECKSUM_EN, stream 01 00 78 56 34 12 + checksum 0x09 -> done=1; same with checksum 0x00 -> error=1, cpu_reset=1.
REQ-039 Header 00 00 -> cpu_reset low and done=1 on the cycle after second header byte; no imem_we.
